// File: rtl/pipe_pkg.sv
// Shared pipeline types and default widths for the MEM/WB stage.
package pipe_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned WB_SEL_W   = 2;
  localparam int unsigned WB_NUM_SRC = 3;

  localparam int unsigned WB_SRC_ALU  = 0;
  localparam int unsigned WB_SRC_LOAD = 1;
  localparam int unsigned WB_SRC_PC4  = 2;

  typedef struct packed {
    logic [WB_NUM_SRC*XLEN-1:0] src_data;
    logic [REG_ADDR_W-1:0]      rd;
    logic                       we;
    logic [WB_SEL_W-1:0]        sel;
    logic [XLEN-1:0]            wb_data;
  } wb_entry_t;

endpackage

// File: rtl/wb_pipe_stage_if.sv
// MEM-side and WB-side handshake channels of the writeback pipeline stage.
interface wb_pipe_stage_if import pipe_pkg::*; #(
  parameter int unsigned DATA_W  = XLEN,
  parameter int unsigned NUM_SRC = WB_NUM_SRC,
  parameter int unsigned SEL_W   = WB_SEL_W,
  parameter int unsigned RD_W    = REG_ADDR_W
);
  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_SRC*DATA_W-1:0] in_src_data;
  logic [RD_W-1:0]           in_rd_addr;
  logic                      in_reg_write_en;
  logic [SEL_W-1:0]          in_wb_sel;

  logic                      out_valid;
  logic                      out_ready;
  logic [NUM_SRC*DATA_W-1:0] out_src_data;
  logic [RD_W-1:0]           out_rd_addr;
  logic                      out_reg_write_en;
  logic [SEL_W-1:0]          out_wb_sel;
  logic [DATA_W-1:0]         out_wb_data;

  modport slave (
    input  in_valid, in_src_data, in_rd_addr, in_reg_write_en, in_wb_sel, out_ready,
    output in_ready, out_valid, out_src_data, out_rd_addr, out_reg_write_en, out_wb_sel,
           out_wb_data
  );

  modport master (
    output in_valid, in_src_data, in_rd_addr, in_reg_write_en, in_wb_sel, out_ready,
    input  in_ready, out_valid, out_src_data, out_rd_addr, out_reg_write_en, out_wb_sel,
           out_wb_data
  );
endinterface

// File: rtl/wb_entry_reg.sv
// Single valid+payload register; reset beats clear, clear beats load.
module wb_entry_reg import pipe_pkg::*; #(
  parameter type entry_t = wb_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   clr_i,
  input  logic   load_i,
  input  entry_t data_i,
  output logic   valid_o,
  output entry_t data_o
);
  logic   valid_q, valid_d;
  entry_t data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/wb_pipe_stage.sv
// MEM/WB pipeline stage with handshake, optional skid entry, flush and pre-selected wb data.
// Optional perf counters are built when WB_PIPE_PERF_CNT_EN is defined.
module wb_pipe_stage import pipe_pkg::*; #(
  parameter int unsigned DATA_W  = XLEN,
  parameter int unsigned NUM_SRC = WB_NUM_SRC,
  parameter int unsigned SEL_W   = WB_SEL_W,
  parameter int unsigned RD_W    = REG_ADDR_W,
  parameter int unsigned SKID    = 1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  wb_pipe_stage_if.slave      bus_io
`ifdef WB_PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    perf_stall_cnt,
  output logic [CNT_W-1:0]    perf_bubble_cnt
`endif
);
  typedef struct packed {
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [RD_W-1:0]           rd;
    logic                      we;
    logic [SEL_W-1:0]          sel;
    logic [DATA_W-1:0]         wb_data;
  } entry_t;

  entry_t            in_entry, m_d, m_q, s_q;
  logic              m_valid, s_valid;
  logic              m_load, m_clr, s_load, s_clr;
  logic              in_ready, in_xfer, out_xfer;
  logic [DATA_W-1:0] sel_data;

  // Out-of-range selects yield zero.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus_io.in_wb_sel == SEL_W'(k)) sel_data = bus_io.in_src_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    in_entry.src_data = bus_io.in_src_data;
    in_entry.rd       = bus_io.in_rd_addr;
    in_entry.we       = bus_io.in_reg_write_en && (bus_io.in_rd_addr != '0);
    in_entry.sel      = bus_io.in_wb_sel;
    in_entry.wb_data  = sel_data;
  end

  always_comb begin
    m_load   = 1'b0;
    m_clr    = 1'b0;
    s_load   = 1'b0;
    s_clr    = 1'b0;
    m_d      = in_entry;
    in_ready = (SKID != 0) ? !s_valid : (!m_valid || bus_io.out_ready);
    in_ready = in_ready && !rst;
    in_xfer  = bus_io.in_valid && in_ready;
    out_xfer = m_valid && bus_io.out_ready;
    if (flush) begin
      m_clr = 1'b1;
      s_clr = 1'b1;
    end else if (out_xfer && s_valid) begin
      // in_ready is low whenever S is full, so no input can collide here.
      m_load = 1'b1;
      m_d    = s_q;
      s_clr  = 1'b1;
    end else if (in_xfer && (!m_valid || out_xfer)) begin
      m_load = 1'b1;
    end else if (in_xfer) begin
      s_load = 1'b1;
    end else if (out_xfer) begin
      m_clr = 1'b1;
    end
  end

  wb_entry_reg #(.entry_t(entry_t)) u_main (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (m_clr),
    .load_i  (m_load),
    .data_i  (m_d),
    .valid_o (m_valid),
    .data_o  (m_q)
  );

  if (SKID != 0) begin : g_skid
    wb_entry_reg #(.entry_t(entry_t)) u_skid (
      .clk_i   (clk),
      .rst_i   (rst),
      .clr_i   (s_clr),
      .load_i  (s_load),
      .data_i  (in_entry),
      .valid_o (s_valid),
      .data_o  (s_q)
    );
  end else begin : g_no_skid
    assign s_valid = 1'b0;
    assign s_q     = '0;
  end

  assign bus_io.in_ready         = in_ready;
  assign bus_io.out_valid        = m_valid;
  assign bus_io.out_src_data     = m_q.src_data;
  assign bus_io.out_rd_addr      = m_q.rd;
  assign bus_io.out_reg_write_en = m_q.we && m_valid;
  assign bus_io.out_wb_sel       = m_q.sel;
  assign bus_io.out_wb_data      = m_q.wb_data;

`ifdef WB_PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d, bubble_q, bubble_d;

  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (m_valid && !bus_io.out_ready && (stall_q != '1)) stall_d = stall_q + 1'b1;
    if (!m_valid && (bubble_q != '1)) bubble_d = bubble_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign perf_stall_cnt  = stall_q;
  assign perf_bubble_cnt = bubble_q;
`endif
endmodule

// File: doc/wb_pipe_stage.md
Name: wb_pipe_stage

Overview:
- Parametrised successor of the MEM/WB pipeline register.
- Carries N writeback source payloads plus rd/write-enable/select control from MEM to WB.
- Adds a valid/ready handshake, a 2-entry skid buffer (or a single-register mode), flush, bubble-safe write-enable gating, and a registered pre-selected writeback value.
- Sits between the MEM stage and the register-file write port.

Parameters:
DATA_W, 32, width of each source payload and of the selected writeback data
NUM_SRC, 3, number of writeback sources (0=ALU result, 1=load data, 2=PC+4)
SEL_W, 2, width of the writeback select field; must satisfy 2**SEL_W >= NUM_SRC
RD_W, 5, destination register address width
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
CNT_W, 32, perf counter width (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  discard all held entries this cycle
in_valid  in  1  MEM stage offers an entry
in_ready  out  1  stage accepts an entry this cycle
in_src_data  in  NUM_SRC*DATA_W  packed sources; source k occupies bits [k*DATA_W +: DATA_W]
in_rd_addr  in  RD_W  destination register
in_reg_write_en  in  1  entry writes the register file
in_wb_sel  in  SEL_W  selects which source is written back
out_valid  out  1  WB entry valid
out_ready  in  1  WB consumer accepts the entry
out_src_data  out  NUM_SRC*DATA_W  registered sources
out_rd_addr  out  RD_W  registered destination
out_reg_write_en  out  1  write enable, gated by out_valid
out_wb_sel  out  SEL_W  registered select
out_wb_data  out  DATA_W  registered selected source

Behaviour:
- Reset: while rst is high at a clock edge, all storage valid bits, data, rd, sel and write-enable clear to 0. After that edge, all outputs read 0. in_ready is 0 during any cycle in which rst is high.
- Transfers:
  - Input transfer occurs when in_valid && in_ready at the clock edge.
  - Output transfer occurs when out_valid && out_ready at the clock edge.
- Capture-time processing:
  - Select: out_wb_data is taken from source in_wb_sel. If in_wb_sel >= NUM_SRC, the selected value is 0.
  - x0 rule: the stored write enable is in_reg_write_en && (in_rd_addr != 0).
- Output gating: out_reg_write_en = stored write enable && out_valid. The write enable is never 1 on a bubble.
- SKID=1 (main register M, skid register S):
  - in_ready = !S.valid. This is a pure register output, with no combinational path from out_ready.
  - Input transfer while M is empty or draining this cycle: the entry loads M.
  - Input transfer while M is held (out_valid && !out_ready): the entry loads S.
  - Output transfer with S valid: S moves into M and S clears.
  - Latency is 1 cycle from input transfer to out_valid. Full throughput is 1 entry/cycle. Order is strictly FIFO.
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational from out_ready).
  - Single register; latency 1; full throughput.
- Flush:
  - Flush at a clock edge clears M.valid and S.valid. An input offered in the same cycle is dropped.
  - in_ready still follows its normal rule during flush; the entry is simply not stored.
  - Flush has priority over every transfer. rst has priority over flush.
- Boundary cases:
  - Full: M and S both valid, so in_ready = 0; an input transfer and an output transfer in the same cycle cannot occur.
  - Simultaneous in/out with only M valid: M is replaced by the new entry and S stays empty.
  - Reset mid-stream: all in-flight entries are lost and no write enable leaks out.
- Data fields of invalid entries hold their last values and must not be relied on. Only out_reg_write_en is gated.

Optional Feature:
- Macro: WB_PIPE_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt [CNT_W] and perf_bubble_cnt [CNT_W].
  - perf_stall_cnt increments on each cycle with out_valid && !out_ready.
  - perf_bubble_cnt increments on each cycle with !out_valid && !rst.
  - Both counters saturate at all-ones, are cleared by rst, and are not cleared by flush.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - localparams WB_SRC_ALU=0, WB_SRC_LOAD=1, WB_SRC_PC4=2.
  - The default widths: XLEN=32, REG_ADDR_W=5, WB_SEL_W=2.
  - A packed struct wb_entry_t containing src_data, rd, we, sel and wb_data.
- One natural sub-module: wb_entry_reg, a single valid+payload register with load/clear controls. It is instantiated once for M and, when SKID=1, once more for S.
- The select mux and the x0 rule stay in the top level.

Test Plan:
- Reset then idle: hold rst high for 2 cycles, then low. Required: all outputs 0 and in_ready=0 during reset; in_ready=1 in the first cycle after reset; out_valid=0.
- Streaming: 10 back-to-back entries with out_ready=1 and sources {A=0x11, L=0x22, P=0x33}, sel cycling 0,1,2,3. Required: out_wb_data sequence 0x11,0x22,0x33,0x0, each one cycle after input, no gaps, in order.
- Backpressure (SKID=1): drop out_ready for 3 cycles while in_valid is held. Required: exactly 2 entries stored, in_ready=0 from the cycle after the 2nd capture, and no loss or duplication after release.
- x0 and bubble gating: entry with rd=0 and we=1. Required: out_reg_write_en=0. Idle cycles: out_reg_write_en=0.
- Flush: with M and S full and in_valid=1, assert flush for 1 cycle. Required: out_valid=0 and in_ready=1 next cycle; the flushed and offered entries never appear.
- Perf counters (WB_PIPE_PERF_CNT_EN defined): 4 stall cycles and 3 bubble cycles. Required: perf_stall_cnt=4 and perf_bubble_cnt=3. With CNT_W=2, the stall counter holds at 3.
